// File: rtl/spi_master_param_if.sv
// SPI master bus bundle: controller handshake plus the SPI pins.
// Define SPI_LOOPBACK_EN to add the loopback request input.
interface spi_master_param_if #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 2,
   parameter int DIV_W  = 8
);
   logic                      start;
   logic [DATA_W-1:0]         tx_data;
   logic [$clog2(NUM_SS)-1:0] ss_sel;
   logic [DIV_W-1:0]          clk_div;
   logic                      cpol;
   logic                      cpha;
   logic                      lsb_first;
   logic                      busy;
   logic                      done;
   logic [DATA_W-1:0]         rx_data;
   logic                      sclk;
   logic                      mosi;
   logic [NUM_SS-1:0]         ss_n;
   logic                      miso;
`ifdef SPI_LOOPBACK_EN
   logic                      loopback;
`endif

   // Master side: the SPI controller itself.
   modport master (
      input  start, tx_data, ss_sel, clk_div, cpol, cpha, lsb_first, miso,
`ifdef SPI_LOOPBACK_EN
      input  loopback,
`endif
      output busy, done, rx_data, sclk, mosi, ss_n
   );

   // Slave side: whoever issues requests and models the SPI slave.
   modport slave (
      output start, tx_data, ss_sel, clk_div, cpol, cpha, lsb_first, miso,
`ifdef SPI_LOOPBACK_EN
      output loopback,
`endif
      input  busy, done, rx_data, sclk, mosi, ss_n
   );
endinterface

// File: rtl/spi_master_param.sv
// Parameterised SPI master: all four modes, selectable bit order,
// programmable SCLK half-period of clk_div+1 clocks, NUM_SS selects.
// Optional feature: define SPI_LOOPBACK_EN for internal mosi->rx loopback.
module spi_master_param #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 2,
   parameter int DIV_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   spi_master_param_if.master bus
);
   localparam int SEL_W = $clog2(NUM_SS);
   localparam int HP_W  = $clog2(2 * DATA_W);
   localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t            state_q, state_d;
   logic              run_q;        // low only until the first edge after reset
   logic [DIV_W:0]    cnt_q, cnt_d; // one spare bit: HOLD counts to clk_div+1
   logic [HP_W-1:0]   hp_q, hp_d;   // XFER half-period index
   logic [DIV_W-1:0]  div_q, div_d;
   logic              cpha_q, cpha_d;
   logic              lsb_q, lsb_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              lb_q, lb_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic              sclk_q, sclk_d; // loaded with cpol on accept
   logic              done_q, done_d;

   logic              active, accept, hp_end, hold_end;
   logic              tog, lead, trail, sample, shift;
   logic              mosi_bit, in_bit, ss_hit;
   logic [NUM_SS-1:0] ss_n_c;

   assign active   = (state_q != IDLE);
   assign accept   = (state_q == IDLE) && run_q && bus.start;
   assign hp_end   = (cnt_q == {1'b0, div_q});
   // HOLD runs one clock past a half-period so done lands a cycle after
   // the final half-period, leaving slave hold margin before ss_n rises.
   assign hold_end = (cnt_q == ({1'b0, div_q} + 1'b1));

   // SCLK edge e=0 is at SETUP exit, e=k+1 at the end of XFER half-period k;
   // even edges are leading, odd edges trailing; no toggle into HOLD.
   assign tog    = hp_end && ((state_q == SETUP) || ((state_q == XFER) && (hp_q != HP_LAST)));
   assign lead   = tog && ((state_q == SETUP) || hp_q[0]);
   assign trail  = tog && !lead;
   assign sample = cpha_q ? trail : lead;
   // cpha=1 shows the first bit from SETUP, so the first leading edge has nothing to shift.
   assign shift  = cpha_q ? (lead && (state_q == XFER)) : trail;

   assign mosi_bit = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
`ifdef SPI_LOOPBACK_EN
   assign in_bit = lb_q ? mosi_bit : bus.miso;
`else
   assign in_bit = bus.miso;
   assign lb_q   = 1'b0;
   assign lb_d   = 1'b0;
`endif

   // Next-state, counters, shift registers and result capture.
   always_comb begin
      // NOTE: every _d gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      hp_d    = hp_q;
      div_d   = div_q;
      cpha_d  = cpha_q;
      lsb_d   = lsb_q;
      sel_d   = sel_q;
`ifdef SPI_LOOPBACK_EN
      lb_d    = lb_q;
`endif
      tx_d    = tx_q;
      rx_sr_d = rx_sr_q;
      rx_d    = rx_q;
      sclk_d  = sclk_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = SETUP;
               hp_d    = '0;
               div_d   = bus.clk_div;
               cpha_d  = bus.cpha;
               lsb_d   = bus.lsb_first;
               sel_d   = bus.ss_sel;
`ifdef SPI_LOOPBACK_EN
               lb_d    = bus.loopback;
`endif
               tx_d    = bus.tx_data;
               rx_sr_d = '0;
               sclk_d  = bus.cpol;
            end
         end
         SETUP: begin
            if (hp_end) begin
               state_d = XFER;
               cnt_d   = '0;
               sclk_d  = ~sclk_q;
            end
         end
         XFER: begin
            if (hp_end) begin
               cnt_d = '0;
               if (hp_q == HP_LAST) begin
                  state_d = HOLD;
               end else begin
                  hp_d   = hp_q + 1'b1;
                  sclk_d = ~sclk_q;
               end
            end
         end
         HOLD: begin
            if (hold_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
               rx_d    = rx_sr_q;
            end
         end
      endcase

      if (sample) rx_sr_d = lsb_q ? {in_bit, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], in_bit};
      if (shift)  tx_d    = lsb_q ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
   end

   // State and datapath registers; reset discards any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
         cnt_q   <= '0;
         hp_q    <= '0;
         div_q   <= '0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         sel_q   <= '0;
         tx_q    <= '0;
         rx_sr_q <= '0;
         rx_q    <= '0;
         sclk_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register updates from pre-edge values.
         state_q <= state_d;
         run_q   <= 1'b1;
         cnt_q   <= cnt_d;
         hp_q    <= hp_d;
         div_q   <= div_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         sel_q   <= sel_d;
         tx_q    <= tx_d;
         rx_sr_q <= rx_sr_d;
         rx_q    <= rx_d;
         sclk_q  <= sclk_d;
         done_q  <= done_d;
      end
   end

`ifdef SPI_LOOPBACK_EN
   // Loopback request, latched with the rest of the transfer setup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lb_q <= 1'b0;
      else        lb_q <= lb_d;
   end
`endif

   // Select decode: out-of-range selects and loopback keep every ss_n high.
   assign ss_hit = active && !lb_q && ({1'b0, sel_q} < (SEL_W + 1)'(NUM_SS));
   always_comb begin
      ss_n_c = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (ss_hit && (sel_q == SEL_W'(i))) ss_n_c[i] = 1'b0;
      end
   end

   assign bus.busy    = active;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_q;
   assign bus.mosi    = active & mosi_bit;
   assign bus.sclk    = run_q & (active ? sclk_q : bus.cpol);
   assign bus.ss_n    = ss_n_c;
endmodule
